id_ex_decode: RTL and testbench
===============================

Name: id_ex_decode

Overview:
- Instruction-decode stage plus ID/EX pipeline register for the RV32I pipelined core.
- Converts a 32-bit instruction into the 4-bit ALU control code, operand selects, immediate and write enables.
- Registers these outputs, with stall/flush control, for the execute stage.
- It is the producer side of the ALU control interface: every ALU code driven here uses the execute-stage ALU encoding exactly.

Parameters:
- XLEN, 32, datapath/PC width; only 32 is supported.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous active-low reset
- valid_d  in  1  decode-stage instruction valid
- instr_d  in  32  instruction word
- pc_d  in  XLEN  instruction PC
- stall_e  in  1  hold ID/EX register contents
- flush_e  in  1  load a bubble into ID/EX
- valid_e  out  1  execute-stage slot holds an instruction
- alu_ctrl_e  out  4  ALU code: ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9 LUI=10 JAL=11
- src_a_pc_e  out  1  1: srcA=PC, 0: srcA=rs1
- src_b_imm_e  out  1  1: srcB=imm, 0: srcB=rs2
- imm_e  out  XLEN  sign-extended immediate
- rs1_e, rs2_e, rd_e  out  5 each  register indices (hazard unit)
- pc_e  out  XLEN  registered PC
- reg_write_e  out  1  writes rd
- mem_write_e  out  1  store
- result_src_e  out  2  0 ALU, 1 load data, 2 reserved
- branch_e  out  1  conditional branch
- jump_e  out  1  JAL/JALR
- jalr_e  out  1  target is rs1+imm
- funct3_e  out  3  load/store size and branch condition
- illegal_e  out  1  instruction is illegal

Behaviour:
- Decode is combinational; outputs are registered. Latency is 1 cycle from instr_d to the *_e outputs.
- Register update priority on each rising clk edge: !rst_n > flush_e > stall_e > load.
- Reset and flush both load a bubble: all outputs 0, so valid_e=0 and alu_ctrl_e=ADD.
- stall_e=1 (no flush): every *_e output holds its value.
- flush_e and stall_e both 1: flush wins and a bubble is loaded.
- valid_d=0 during a load: a bubble is loaded.
- Reset asserted mid-stream: the bubble appears the cycle after the reset edge, and the in-flight instruction is discarded.
- Decode map for the ALU code (alu_ctrl_e / src_a_pc_e / src_b_imm_e):
  - OP (0110011): funct3/funct7 → ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND; A=rs1, B=rs2.
  - OP-IMM (0010011): same map; SUB is never produced; SRAI when funct7=0100000; B=imm I.
  - LOAD (0000011): ADD, B=imm I, result_src=1.
  - STORE (0100011): ADD, B=imm S, mem_write=1, reg_write=0.
  - BRANCH (1100011): SUB for funct3 0/1, SLT for 4/5, SLTU for 6/7; A=rs1, B=rs2, imm B-type, branch=1, reg_write=0.
  - JAL (1101111): JAL, A=PC, imm J-type, jump=1.
  - JALR (1100111): JAL, A=PC, imm I-type, jump=1, jalr=1.
  - LUI (0110111): LUI, B=imm U.
  - AUIPC (0010111): ADD, A=PC, B=imm U.
- Immediates: I, S, B, J are sign-extended from instr[31]. U is {instr[31:12],12'b0}. The B and J LSB is 0.
- reg_write_e=1 for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC, even when rd=0.

Optional Feature:
- Macro: DECODE_ILLEGAL_EN.
- Defined: illegal_e=1 when any of the following hold:
  - instr[1:0]!=11 or opcode is unlisted;
  - R-type funct7 is not 0000000/0100000, or is 0100000 with funct3 not in {000,101};
  - shift-imm funct7 is invalid;
  - LOAD funct3 not in {0,1,2,4,5};
  - STORE funct3 >2;
  - BRANCH funct3 is 2 or 3;
  - JALR funct3 !=0.
- When illegal: valid_e=1; reg_write, mem_write, branch and jump all forced 0; alu_ctrl_e=ADD.
- Undefined: illegal_e is tied 0. Unlisted encodings decode as ADD with all write enables 0, i.e. a NOP.

Test Plan:
- Reset held low 2 cycles, then released with valid_d=0 → every output is 0 on each cycle.
- ADDI x5,x1,-3 (0xFFD08293), pc_d=0x100 → next cycle: alu_ctrl_e=0, src_b_imm_e=1, imm_e=0xFFFFFFFD, rd_e=5, reg_write_e=1, pc_e=0x100, valid_e=1.
- SUB x3,x1,x2 (0x402081B3) → alu_ctrl_e=1, src_b_imm_e=0. Then SRAI x4,x4,7 (0x40725213) → alu_ctrl_e=7, imm_e[4:0]=7.
- LUI x7,0x12345 (0x123453B7) → alu_ctrl_e=10, imm_e=0x12345000. Then JAL x1,+8 (0x008000EF) at pc_d=0x200 → alu_ctrl_e=11, src_a_pc_e=1, imm_e=8, jump_e=1.
- Load BLTU, then stall_e=1 for 3 cycles → outputs are unchanged (alu_ctrl_e=4, branch_e=1). Next cycle stall_e=1 and flush_e=1 → valid_e=0, branch_e=0.
- With DECODE_ILLEGAL_EN, instr 0xFFFFFFFF → illegal_e=1, valid_e=1, reg_write_e=0, mem_write_e=0. Without the macro → illegal_e=0, alu_ctrl_e=0.

Source files
------------

// File: rtl/id_ex_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_decode: RV32I decode plus ID/EX pipeline register (stall/flush).   |
// | Optional DECODE_ILLEGAL_EN: flag illegal encodings. Revision 1.0         |
// +--------------------------------------------------------------------------+
module id_ex_decode #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_d,
  input  logic [31:0]     instr_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic            stall_e,
  input  logic            flush_e,
  output logic            valid_e,
  output logic [3:0]      alu_ctrl_e,
  output logic            src_a_pc_e,
  output logic            src_b_imm_e,
  output logic [XLEN-1:0] imm_e,
  output logic [4:0]      rs1_e,
  output logic [4:0]      rs2_e,
  output logic [4:0]      rd_e,
  output logic [XLEN-1:0] pc_e,
  output logic            reg_write_e,
  output logic            mem_write_e,
  output logic [1:0]      result_src_e,
  output logic            branch_e,
  output logic            jump_e,
  output logic            jalr_e,
  output logic [2:0]      funct3_e,
  output logic            illegal_e
);

  localparam logic [3:0] c_ALU_ADD  = 4'd0;
  localparam logic [3:0] c_ALU_SUB  = 4'd1;
  localparam logic [3:0] c_ALU_SLL  = 4'd2;
  localparam logic [3:0] c_ALU_SLT  = 4'd3;
  localparam logic [3:0] c_ALU_SLTU = 4'd4;
  localparam logic [3:0] c_ALU_XOR  = 4'd5;
  localparam logic [3:0] c_ALU_SRL  = 4'd6;
  localparam logic [3:0] c_ALU_SRA  = 4'd7;
  localparam logic [3:0] c_ALU_OR   = 4'd8;
  localparam logic [3:0] c_ALU_AND  = 4'd9;
  localparam logic [3:0] c_ALU_LUI  = 4'd10;
  localparam logic [3:0] c_ALU_JAL  = 4'd11;

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic            valid;
    logic [3:0]      alu;
    logic            a_pc;
    logic            b_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] pc;
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic [2:0]      funct3;
    logic            illegal;
  } ex_t;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [3:0]      w_alu_f3;
  ex_t             w_dec;
  ex_t             r_ex;

  assign w_opcode = instr_d[6:0];
  assign w_funct3 = instr_d[14:12];

  assign w_imm_i = {{20{instr_d[31]}}, instr_d[31:20]};
  assign w_imm_s = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
  assign w_imm_b = {{19{instr_d[31]}}, instr_d[31], instr_d[7], instr_d[30:25], instr_d[11:8], 1'b0};
  assign w_imm_u = {instr_d[31:12], 12'b0};
  assign w_imm_j = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12], instr_d[20], instr_d[30:21], 1'b0};

  // Shared OP/OP-IMM map; instr[30] selects SUB/SRA, OP-IMM masks SUB later.
  always_comb begin
    w_alu_f3 = c_ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_f3 = instr_d[30] ? c_ALU_SUB : c_ALU_ADD;
      3'b001:  w_alu_f3 = c_ALU_SLL;
      3'b010:  w_alu_f3 = c_ALU_SLT;
      3'b011:  w_alu_f3 = c_ALU_SLTU;
      3'b100:  w_alu_f3 = c_ALU_XOR;
      3'b101:  w_alu_f3 = instr_d[30] ? c_ALU_SRA : c_ALU_SRL;
      3'b110:  w_alu_f3 = c_ALU_OR;
      default: w_alu_f3 = c_ALU_AND;
    endcase
  end

`ifdef DECODE_ILLEGAL_EN
  logic [6:0] w_funct7;
  logic       w_bad;
  assign w_funct7 = instr_d[31:25];

  always_comb begin
    w_bad = 1'b0;
    case (w_opcode)
      c_OPC_OP:     w_bad = !((w_funct7 == 7'b0000000) ||
                              (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101)));
      c_OPC_OP_IMM: begin
        if (w_funct3 == 3'b001)
          w_bad = (w_funct7 != 7'b0000000);
        else if (w_funct3 == 3'b101)
          w_bad = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
      end
      c_OPC_LOAD:   w_bad = (w_funct3 == 3'd3) || (w_funct3 == 3'd6) || (w_funct3 == 3'd7);
      c_OPC_STORE:  w_bad = (w_funct3 > 3'd2);
      c_OPC_BRANCH: w_bad = (w_funct3[2:1] == 2'b01);
      c_OPC_JALR:   w_bad = (w_funct3 != 3'd0);
      c_OPC_JAL, c_OPC_LUI, c_OPC_AUIPC: w_bad = 1'b0;
      default:      w_bad = 1'b1;
    endcase
    if (instr_d[1:0] != 2'b11) w_bad = 1'b1;
  end
`endif

  // R-type and unlisted opcodes carry a zero immediate.
  always_comb begin
    w_dec        = '0;
    w_dec.valid  = 1'b1;
    w_dec.rs1    = instr_d[19:15];
    w_dec.rs2    = instr_d[24:20];
    w_dec.rd     = instr_d[11:7];
    w_dec.pc     = pc_d;
    w_dec.funct3 = w_funct3;
    case (w_opcode)
      c_OPC_OP: begin
        w_dec.alu       = w_alu_f3;
        w_dec.reg_write = 1'b1;
      end
      c_OPC_OP_IMM: begin
        w_dec.alu       = (w_funct3 == 3'b000) ? c_ALU_ADD : w_alu_f3;
        w_dec.b_imm     = 1'b1;
        w_dec.imm       = w_imm_i;
        w_dec.reg_write = 1'b1;
      end
      c_OPC_LOAD: begin
        w_dec.b_imm      = 1'b1;
        w_dec.imm        = w_imm_i;
        w_dec.reg_write  = 1'b1;
        w_dec.result_src = 2'd1;
      end
      c_OPC_STORE: begin
        w_dec.b_imm     = 1'b1;
        w_dec.imm       = w_imm_s;
        w_dec.mem_write = 1'b1;
      end
      c_OPC_BRANCH: begin
        w_dec.alu    = (w_funct3[2:1] == 2'b11) ? c_ALU_SLTU :
                       (w_funct3[2:1] == 2'b10) ? c_ALU_SLT : c_ALU_SUB;
        w_dec.imm    = w_imm_b;
        w_dec.branch = 1'b1;
      end
      c_OPC_JAL: begin
        w_dec.alu       = c_ALU_JAL;
        w_dec.a_pc      = 1'b1;
        w_dec.imm       = w_imm_j;
        w_dec.jump      = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      c_OPC_JALR: begin
        w_dec.alu       = c_ALU_JAL;
        w_dec.a_pc      = 1'b1;
        w_dec.imm       = w_imm_i;
        w_dec.jump      = 1'b1;
        w_dec.jalr      = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      c_OPC_LUI: begin
        w_dec.alu       = c_ALU_LUI;
        w_dec.b_imm     = 1'b1;
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      c_OPC_AUIPC: begin
        w_dec.a_pc      = 1'b1;
        w_dec.b_imm     = 1'b1;
        w_dec.imm       = w_imm_u;
        w_dec.reg_write = 1'b1;
      end
      default: ;
    endcase
`ifdef DECODE_ILLEGAL_EN
    if (w_bad) begin
      w_dec.illegal   = 1'b1;
      w_dec.alu       = c_ALU_ADD;
      w_dec.reg_write = 1'b0;
      w_dec.mem_write = 1'b0;
      w_dec.branch    = 1'b0;
      w_dec.jump      = 1'b0;
      w_dec.jalr      = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_e)
      r_ex <= '0;
    else if (!stall_e)
      r_ex <= valid_d ? w_dec : '0;
  end

  assign valid_e      = r_ex.valid;
  assign alu_ctrl_e   = r_ex.alu;
  assign src_a_pc_e   = r_ex.a_pc;
  assign src_b_imm_e  = r_ex.b_imm;
  assign imm_e        = r_ex.imm;
  assign rs1_e        = r_ex.rs1;
  assign rs2_e        = r_ex.rs2;
  assign rd_e         = r_ex.rd;
  assign pc_e         = r_ex.pc;
  assign reg_write_e  = r_ex.reg_write;
  assign mem_write_e  = r_ex.mem_write;
  assign result_src_e = r_ex.result_src;
  assign branch_e     = r_ex.branch;
  assign jump_e       = r_ex.jump;
  assign jalr_e       = r_ex.jalr;
  assign funct3_e     = r_ex.funct3;
  assign illegal_e    = r_ex.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_ex_decode: directed vectors with a scoreboard queue for id_ex_decode|
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_id_ex_decode;

  typedef logic [96:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n, valid_d, stall_e, flush_e;
  logic [31:0] instr_d, pc_d;
  logic        valid_e, src_a_pc_e, src_b_imm_e, reg_write_e, mem_write_e;
  logic        branch_e, jump_e, jalr_e, illegal_e;
  logic [3:0]  alu_ctrl_e;
  logic [31:0] imm_e, pc_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [1:0]  result_src_e;
  logic [2:0]  funct3_e;

  vec_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

`ifdef DECODE_ILLEGAL_EN
  localparam logic ILL = 1'b1;
`else
  localparam logic ILL = 1'b0;
`endif
  localparam vec_t BUB = '0;

  always #5 clk = ~clk;

  id_ex_decode #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
    .stall_e(stall_e), .flush_e(flush_e), .valid_e(valid_e), .alu_ctrl_e(alu_ctrl_e),
    .src_a_pc_e(src_a_pc_e), .src_b_imm_e(src_b_imm_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_e(pc_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .result_src_e(result_src_e), .branch_e(branch_e),
    .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e), .illegal_e(illegal_e)
  );

  vec_t act;
  assign act = {valid_e, alu_ctrl_e, src_a_pc_e, src_b_imm_e, imm_e, rs1_e, rs2_e, rd_e,
                pc_e, reg_write_e, mem_write_e, result_src_e, branch_e, jump_e, jalr_e,
                funct3_e, illegal_e};

  function automatic vec_t mk(input logic v, input logic [3:0] alu, input logic apc,
                              input logic bimm, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] pc, input logic rw, input logic mw,
                              input logic [1:0] rsrc, input logic br, input logic jmp,
                              input logic jr, input logic [2:0] f3, input logic ill);
    return {v, alu, apc, bimm, imm, rs1, rs2, rd, pc, rw, mw, rsrc, br, jmp, jr, f3, ill};
  endfunction

  task automatic drive(input logic rn, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc, input logic st, input logic fl,
                       input vec_t e, input string n);
    @(negedge clk);
    rst_n = rn; valid_d = v; instr_d = ins; pc_d = pc; stall_e = st; flush_e = fl;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // Monitor: every registered slot (bubble or instruction) is checked a step after the edge.
  initial begin
    vec_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, act, e);
        end
      end
    end
  end

  initial begin
    vec_t addi_v, bltu_v;
    rst_n = 1'b0; valid_d = 1'b0; instr_d = '0; pc_d = '0; stall_e = 1'b0; flush_e = 1'b0;
    addi_v = mk(1, 4'd0, 0, 1, 32'hFFFFFFFD, 5'd1, 5'd29, 5'd5, 32'h100, 1, 0, 2'd0, 0, 0, 0, 3'd0, 0);
    bltu_v = mk(1, 4'd4, 0, 0, 32'd16, 5'd1, 5'd2, 5'd16, 32'h300, 0, 0, 2'd0, 1, 0, 0, 3'd6, 0);

    drive(0, 0, 32'h0,        32'h0,   0, 0, BUB, "reset0");
    drive(0, 1, 32'hFFD08293, 32'h100, 0, 0, BUB, "reset1");
    drive(1, 0, 32'h0,        32'h0,   0, 0, BUB, "idle0");
    drive(1, 0, 32'hFFD08293, 32'h100, 0, 0, BUB, "idle1");
    drive(1, 1, 32'hFFD08293, 32'h100, 0, 0, addi_v, "addi");
    drive(1, 1, 32'h402081B3, 32'h104, 0, 0,
          mk(1, 4'd1, 0, 0, 32'h0, 5'd1, 5'd2, 5'd3, 32'h104, 1, 0, 2'd0, 0, 0, 0, 3'd0, 0), "sub");
    drive(1, 1, 32'h40725213, 32'h108, 0, 0,
          mk(1, 4'd7, 0, 1, 32'h407, 5'd4, 5'd7, 5'd4, 32'h108, 1, 0, 2'd0, 0, 0, 0, 3'd5, 0), "srai");
    drive(1, 1, 32'h123453B7, 32'h10C, 0, 0,
          mk(1, 4'd10, 0, 1, 32'h12345000, 5'd8, 5'd3, 5'd7, 32'h10C, 1, 0, 2'd0, 0, 0, 0, 3'd5, 0), "lui");
    drive(1, 1, 32'h008000EF, 32'h200, 0, 0,
          mk(1, 4'd11, 1, 0, 32'd8, 5'd0, 5'd8, 5'd1, 32'h200, 1, 0, 2'd0, 0, 1, 0, 3'd0, 0), "jal");
    drive(1, 1, 32'h00408067, 32'h204, 0, 0,
          mk(1, 4'd11, 1, 0, 32'd4, 5'd1, 5'd4, 5'd0, 32'h204, 1, 0, 2'd0, 0, 1, 1, 3'd0, 0), "jalr");
    drive(1, 1, 32'h0020A423, 32'h208, 0, 0,
          mk(1, 4'd0, 0, 1, 32'd8, 5'd1, 5'd2, 5'd8, 32'h208, 0, 1, 2'd0, 0, 0, 0, 3'd2, 0), "sw");
    drive(1, 1, 32'hFFC12303, 32'h20C, 0, 0,
          mk(1, 4'd0, 0, 1, 32'hFFFFFFFC, 5'd2, 5'd28, 5'd6, 32'h20C, 1, 0, 2'd1, 0, 0, 0, 3'd2, 0), "lw");
    drive(1, 1, 32'h0020E863, 32'h300, 0, 0, bltu_v, "bltu");
    for (int i = 0; i < 3; i++)
      drive(1, 1, 32'hFFD08293, 32'h400, 1, 0, bltu_v, "stall_hold");
    drive(1, 1, 32'hFFD08293, 32'h400, 1, 1, BUB, "stall_flush");
    drive(1, 0, 32'hFFD08293, 32'h404, 0, 0, BUB, "valid_low");
    drive(1, 1, 32'hFFFFFFFF, 32'h400, 0, 0,
          mk(1, 4'd0, 0, 0, 32'h0, 5'd31, 5'd31, 5'd31, 32'h400, 0, 0, 2'd0, 0, 0, 0, 3'd7, ILL), "all_ones");
    drive(1, 1, 32'h402081B3, 32'h408, 0, 1, BUB, "flush");
    drive(1, 1, 32'hFFD08293, 32'h100, 0, 0, addi_v, "addi_again");
    drive(0, 1, 32'h402081B3, 32'h104, 0, 0, BUB, "reset_mid");
    drive(1, 0, 32'h0,        32'h0,   0, 0, BUB, "after_reset");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expected slots left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
